rdx_twdl_idx_gen: RTL
=====================

Name: rdx_twdl_idx_gen

Overview:
- Generates per-butterfly twiddle exponent indices (numerators), the shared denominator and the radix factor for one mixed-radix CTA stage.
- Sits directly upstream of the twiddle multiplier stage and is driven by the radix butterfly's valid strobe.
- For butterfly k within a sub-DFT group of length L = M/r, lane i receives numerator (i*k) mod M. Indices are advanced incrementally, with no multipliers.

Parameters:
- wIdx, 12, width of numerator, denominator and butterfly counter.
- nLane, 5, number of lanes (fixed at 5 by the downstream interface).

Ports:
- clk  in  1  stage clock
- rst  in  1  synchronous active-high reset
- cfg_load  in  1  one-cycle strobe; latches cfg_* and arms a frame
- cfg_factor  in  3  radix r, legal values 2..5
- cfg_demontr  in  wIdx  M, sub-DFT length; M = r*L
- cfg_nbfly  in  wIdx  butterflies per frame, at least 1
- in_val  in  1  butterfly output valid from the upstream radix kernel
- out_val  out  1  index set valid, aligned to in_val delayed one cycle
- twdl_numrtr  out  [0:4][wIdx]  per-lane numerators
- twdl_demontr  out  wIdx  latched M
- factor  out  3  latched r
- busy  out  1  high in RUN
- frame_done  out  1  one-cycle pulse after the last butterfly

Behaviour:
- Reset: all outputs are 0, state is IDLE, and all accumulators and counters are 0.
- States:
  - IDLE: on cfg_load, latch the config, clear acc[0..4], kcnt and bcnt, then go to RUN.
  - RUN: process butterflies as below; when in_val arrives with bcnt == cfg_nbfly-1, go to DONE.
  - DONE: lasts exactly one cycle; frame_done=1; then go to IDLE.
- Per in_val in RUN:
  - The outputs take acc[i] for i < r, and 0 for lanes i >= r; lane 0 is always 0.
  - Then acc[i] becomes acc[i]+i, minus M if the sum is >= M. One subtraction suffices because i <= r-1 < M/2 whenever L > 1.
  - kcnt increments. When kcnt == L-1, it wraps to 0 and all acc are cleared.
  - bcnt increments.
- L is derived once at cfg_load by repeated subtraction of r from M, up to 2^wIdx/2 cycles. busy stays low and in_val is ignored until L is ready. busy rises when L is ready.
- M == r (L == 1): all numerators stay 0 for the whole frame.
- Latency: one cycle from in_val to out_val. With no in_val, out_val=0 and the numerators hold their last value.
- twdl_demontr and factor are registered at cfg_load and hold until the next cfg_load.
- cfg_load during RUN: the frame is aborted and the new config is latched on the same cycle. frame_done is not pulsed.
- cfg_load coinciding with in_val in RUN: cfg_load wins, and that in_val produces no output.
- in_val in IDLE or DONE: ignored, out_val=0.
- rst mid-frame: returns to the reset state on the next edge, with no frame_done.

Optional Feature:
- Macro: RDX_IDX_ERR_EN.
- When defined:
  - Adds output err_sticky (1 bit), set on in_val outside RUN or on a cfg_load with an illegal config (r outside 2..5, or M not a multiple of r).
  - err_sticky clears only on rst.
  - An illegal config leaves the block in IDLE.
- When not defined: no port and no checks; an illegal config gives undefined indices.

Decomposition:
- Shared package rdx_pkg holds:
  - localparams RDX_MAX_LANE=5 and RDX_WIDX=12;
  - typedef rdx_idx_t (logic [11:0]);
  - typedef rdx_lane_idx_t (rdx_idx_t [0:4]);
  - enum rdx_idx_state_e {IDLE, RUN, DONE}.
- One sub-module, rdx_len_div, performs the sequential M/r division for L with start/done handshake. The accumulators stay in the top level.

Test Plan:
- r=5, M=25, nbfly=5, in_val back-to-back: k=0..4 give lane numerators {0,0,0,0,0}, {0,1,2,3,4}, {0,2,4,6,8}, {0,3,6,9,12}, {0,4,8,12,16}; out_val high for 5 cycles one cycle after in_val; frame_done one cycle after the last in_val.
- r=4, M=16, nbfly=8: butterfly 3 gives {0,3,6,9,0}; butterfly 4 restarts at {0,0,0,0,0} (L=4 wrap); lane 4 is always 0.
- r=3, M=3, nbfly=4: all numerators 0; twdl_demontr=3, factor=3.
- r=2, M=12 (L=6), in_val with gaps (1 on, 2 off): numerators advance only on in_val; held values are unchanged while out_val=0.
- Abort and reset: cfg_load mid-frame gives no frame_done and restarts at k=0; rst asserted mid-frame clears all outputs next cycle.
- RDX_IDX_ERR_EN defined: cfg_factor=6 gives err_sticky=1 and busy stays 0; in_val in IDLE also sets err_sticky.

Source files
------------

// File: rtl/rdx_pkg.sv
// rdx_pkg: shared types, widths and helpers for the mixed-radix twiddle index generator.
// Config legality helper is only referenced when RDX_IDX_ERR_EN is defined.
package rdx_pkg;

   localparam int RDX_MAX_LANE = 5;
   localparam int RDX_WIDX     = 12;

   typedef logic [RDX_WIDX-1:0] rdx_idx_t;
   typedef rdx_idx_t [0:RDX_MAX_LANE-1] rdx_lane_idx_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} rdx_idx_state_e;

   // A config is legal when r is 2..5 and M is an exact multiple of r.
   function automatic logic rdx_cfg_legal(input logic [2:0] r, input rdx_idx_t m);
      logic ok;
      case (r)
         3'd2:    ok = (m % rdx_idx_t'(2)) == '0;
         3'd3:    ok = (m % rdx_idx_t'(3)) == '0;
         3'd4:    ok = (m % rdx_idx_t'(4)) == '0;
         3'd5:    ok = (m % rdx_idx_t'(5)) == '0;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/rdx_twdl_idx_gen_if.sv
// rdx_twdl_idx_gen_if: config strobe, butterfly valid and per-lane index outputs.
// Macro RDX_IDX_ERR_EN adds the err_sticky status signal.
interface rdx_twdl_idx_gen_if
   import rdx_pkg::*;
#(
   parameter int wIdx  = RDX_WIDX,
   parameter int nLane = RDX_MAX_LANE
) ();

   logic                          cfg_load;
   logic [2:0]                    cfg_factor;
   logic [wIdx-1:0]               cfg_demontr;
   logic [wIdx-1:0]               cfg_nbfly;
   logic                          in_val;
   logic                          out_val;
   logic [0:nLane-1][wIdx-1:0]    twdl_numrtr;
   logic [wIdx-1:0]               twdl_demontr;
   logic [2:0]                    factor;
   logic                          busy;
   logic                          frame_done;
`ifdef RDX_IDX_ERR_EN
   logic                          err_sticky;
`endif

   modport master (
      output cfg_load, cfg_factor, cfg_demontr, cfg_nbfly, in_val,
      input  out_val, twdl_numrtr, twdl_demontr, factor, busy, frame_done
`ifdef RDX_IDX_ERR_EN
      , input err_sticky
`endif
   );

   modport slave (
      input  cfg_load, cfg_factor, cfg_demontr, cfg_nbfly, in_val,
      output out_val, twdl_numrtr, twdl_demontr, factor, busy, frame_done
`ifdef RDX_IDX_ERR_EN
      , output err_sticky
`endif
   );

endinterface

// File: rtl/rdx_len_div.sv
// rdx_len_div: derives L = M / r by repeated subtraction; done stays high until the next start.
module rdx_len_div
   import rdx_pkg::*;
#(
   parameter int wIdx = RDX_WIDX
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [wIdx-1:0] dividend,
   input  logic [2:0]      divisor,
   output logic            done,
   output logic [wIdx-1:0] quotient
);

   localparam logic [wIdx-1:0] ONE = wIdx'(1);

   logic [wIdx-1:0] rem;
   logic [wIdx-1:0] div_ext;
   logic            active;

   assign div_ext = wIdx'(divisor);

   // Subtract one divisor per cycle; a zero divisor terminates at once so the unit can never stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem      <= '0;
         quotient <= '0;
         active   <= 1'b0;
         done     <= 1'b0;
      end else if (start) begin
         rem      <= dividend;
         quotient <= '0;
         active   <= 1'b1;
         done     <= 1'b0;
      end else if (active) begin
         if ((div_ext != '0) && (rem >= div_ext)) begin
            rem      <= rem - div_ext;
            quotient <= quotient + ONE;
         end else begin
            active <= 1'b0;
            done   <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/rdx_twdl_idx_gen.sv
// rdx_twdl_idx_gen: per-lane twiddle numerators (i*k mod M) for one mixed-radix stage.
// Optional feature macro: RDX_IDX_ERR_EN (err_sticky output and config checks).
module rdx_twdl_idx_gen
   import rdx_pkg::*;
#(
   parameter int wIdx  = RDX_WIDX,
   parameter int nLane = RDX_MAX_LANE
) (
   input  logic               clk,
   input  logic               rst,
   rdx_twdl_idx_gen_if.slave  bus
);

   localparam logic [wIdx-1:0] ONE = wIdx'(1);

   rdx_idx_state_e               state;
   rdx_idx_state_e               state_nxt;
   logic [0:nLane-1][wIdx-1:0]   acc;
   logic [0:nLane-1][wIdx-1:0]   acc_nxt;
   logic [0:nLane-1][wIdx:0]     acc_sum;
   logic [0:nLane-1][wIdx-1:0]   lane_out;
   logic [wIdx-1:0]              kcnt;
   logic [wIdx-1:0]              bcnt;
   logic [wIdx-1:0]              m_reg;
   logic [wIdx-1:0]              nbfly_reg;
   logic [2:0]                   r_reg;
   logic [wIdx-1:0]              l_val;
   logic                         l_ready;
   logic                         cfg_ok;
   logic                         load_go;
   logic                         fire;
   logic                         last_bfly;
   logic                         k_wrap;

`ifdef RDX_IDX_ERR_EN
   logic err_q;
   assign cfg_ok         = rdx_cfg_legal(bus.cfg_factor, bus.cfg_demontr);
   assign bus.err_sticky = err_q;
`else
   assign cfg_ok = 1'b1;
`endif

   assign load_go   = bus.cfg_load && cfg_ok;
   assign fire      = (state == RUN) && l_ready && bus.in_val && !bus.cfg_load;
   assign last_bfly = (bcnt == (nbfly_reg - ONE));
   assign k_wrap    = (kcnt == (l_val - ONE));

   rdx_len_div #(.wIdx(wIdx)) u_len_div (
      .clk      (clk),
      .rst      (rst),
      .start    (load_go),
      .dividend (bus.cfg_demontr),
      .divisor  (bus.cfg_factor),
      .done     (l_ready),
      .quotient (l_val)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: any cfg_load restarts (or, if illegal, parks in IDLE); otherwise run the frame.
   always_comb begin
      state_nxt = state;
      if (bus.cfg_load) begin
         state_nxt = load_go ? RUN : IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = IDLE;
            RUN:     if (fire && last_bfly) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State-decoded outputs: busy only once L is known, frame_done for the single DONE cycle.
   always_comb begin
      bus.busy       = (state == RUN) && l_ready;
      bus.frame_done = (state == DONE);
   end

   // Modular accumulator step and lane masking; one subtraction is enough since i < r <= M/2.
   always_comb begin
      acc_sum  = '0;
      acc_nxt  = '0;
      lane_out = '0;
      for (int i = 0; i < nLane; i++) begin
         acc_sum[i] = {1'b0, acc[i]} + (wIdx+1)'(i);
         acc_nxt[i] = (acc_sum[i] >= {1'b0, m_reg}) ? (acc_sum[i][wIdx-1:0] - m_reg)
                                                    : acc_sum[i][wIdx-1:0];
         if ((i != 0) && (i < int'(r_reg))) lane_out[i] = acc[i];
      end
   end

   // Config latch, accumulators, counters and registered index outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc              <= '0;
         kcnt             <= '0;
         bcnt             <= '0;
         m_reg            <= '0;
         nbfly_reg        <= '0;
         r_reg            <= '0;
         bus.out_val      <= 1'b0;
         bus.twdl_numrtr  <= '0;
         bus.twdl_demontr <= '0;
         bus.factor       <= '0;
      end else begin
         bus.out_val <= fire;
         if (bus.cfg_load) begin
            m_reg            <= bus.cfg_demontr;
            nbfly_reg        <= bus.cfg_nbfly;
            r_reg            <= bus.cfg_factor;
            bus.twdl_demontr <= bus.cfg_demontr;
            bus.factor       <= bus.cfg_factor;
            acc              <= '0;
            kcnt             <= '0;
            bcnt             <= '0;
         end else if (fire) begin
            bus.twdl_numrtr <= lane_out;
            bcnt            <= bcnt + ONE;
            if (k_wrap) begin
               acc  <= '0;
               kcnt <= '0;
            end else begin
               acc  <= acc_nxt;
               kcnt <= kcnt + ONE;
            end
         end
      end
   end

`ifdef RDX_IDX_ERR_EN
   // Sticky error: stray in_val outside RUN or an illegal config load; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst)                                          err_q <= 1'b0;
      else if ((bus.in_val && (state != RUN)) ||
               (bus.cfg_load && !cfg_ok))               err_q <= 1'b1;
   end
`endif

endmodule
